// File: rtl/reserved_slot_entry_ctrl.sv
// Entry-gate controller for the reserved parking section: validates a flat number,
// claims its slot in the shared occupancy bitmap, times the barrier and reports status.
// Optional build macro ENTRY_STATS_EN adds a saturating reject_count output.
module reserved_slot_entry_ctrl #(
    parameter int N_SLOTS     = 32,
    parameter int FLAT_W      = $clog2(N_SLOTS + 1),
    parameter int GATE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FLAT_W-1:0]  req_flat,
    input  logic               exit_valid,
    input  logic [FLAT_W-1:0]  exit_flat,
    output logic               rsp_valid,
    output logic [1:0]         rsp_code,
    output logic [FLAT_W-1:0]  rsp_flat,
    output logic               gate_open,
    output logic               exit_err,
    output logic [N_SLOTS-1:0] occ_bitmap,
`ifdef ENTRY_STATS_EN
    output logic [15:0]        reject_count,
`endif
    output logic [FLAT_W-1:0]  occ_count
);

    localparam int TMR_W = $clog2(GATE_CYCLES + 1);
    localparam logic [1:0] CODE_GRANTED  = 2'b00;
    localparam logic [1:0] CODE_OCCUPIED = 2'b01;
    localparam logic [1:0] CODE_INVALID  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_GATE  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [FLAT_W-1:0]    r_flat_q;
    logic [1:0]           r_code;
    logic [1:0]           w_code_next;
    logic [TMR_W-1:0]     r_timer;
    logic [N_SLOTS-1:0]   r_bitmap;
    logic [FLAT_W-1:0]    r_count;
    logic [FLAT_W-1:0]    w_count_next;
    logic                 r_rsp_valid;
    logic [1:0]           r_rsp_code;
    logic [FLAT_W-1:0]    r_rsp_flat;
    logic                 r_gate_open;
    logic                 r_exit_err;
    logic                 w_grant;
    logic                 w_exit_ok;
    logic [N_SLOTS-1:0]   w_hit_vec;
    logic [N_SLOTS-1:0]   w_exit_vec;
    logic [N_SLOTS-1:0]   w_set_vec;
    logic [N_SLOTS-1:0]   w_clr_vec;

    // One-hot slot decode per flat; out-of-range flats simply match no slot.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            localparam logic [FLAT_W-1:0] FLAT_ID = FLAT_W'(gi + 1);
            assign w_hit_vec[gi]  = (r_flat_q == FLAT_ID);
            assign w_exit_vec[gi] = exit_valid && (exit_flat == FLAT_ID);
            assign w_set_vec[gi]  = w_grant && w_hit_vec[gi];
            assign w_clr_vec[gi]  = w_exit_vec[gi] && r_bitmap[gi];
        end
    endgenerate

    assign w_exit_ok = |w_clr_vec;

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_grant      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!(|w_hit_vec)) begin
                    w_code_next  = CODE_INVALID;
                    w_state_next = S_RESP;
                end else if (|(w_hit_vec & r_bitmap)) begin
                    w_code_next  = CODE_OCCUPIED;
                    w_state_next = S_RESP;
                end else begin
                    w_grant      = 1'b1;
                    w_code_next  = CODE_GRANTED;
                    w_state_next = S_GATE;
                end
            end
            S_GATE: begin
                if (r_timer <= TMR_W'(1)) w_state_next = S_RESP;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A grant and a successful exit in the same cycle always touch different slots.
    always_comb begin
        w_count_next = r_count;
        unique case ({w_grant, w_exit_ok})
            2'b10:   w_count_next = r_count + FLAT_W'(1);
            2'b01:   w_count_next = r_count - FLAT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flat_q    <= '0;
            r_code      <= CODE_GRANTED;
            r_timer     <= '0;
            r_bitmap    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= CODE_GRANTED;
            r_rsp_flat  <= '0;
            r_gate_open <= 1'b0;
            r_exit_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
            if (r_state == S_IDLE && req_valid) r_flat_q <= req_flat;
            if (w_grant) begin
                r_timer <= TMR_W'(GATE_CYCLES);
            end else if (r_state == S_GATE) begin
                r_timer <= r_timer - TMR_W'(1);
            end
            r_bitmap    <= (r_bitmap & ~w_clr_vec) | w_set_vec;
            r_count     <= w_count_next;
            r_exit_err  <= exit_valid && !w_exit_ok;
            r_gate_open <= (w_state_next == S_GATE);
            r_rsp_valid <= (w_state_next == S_RESP);
            if (w_state_next == S_RESP) begin
                r_rsp_code <= w_code_next;
                r_rsp_flat <= r_flat_q;
            end
        end
    end

`ifdef ENTRY_STATS_EN
    logic [15:0] r_reject_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reject_count <= '0;
        end else if (r_state == S_RESP && r_code != CODE_GRANTED && r_reject_count != 16'hFFFF) begin
            r_reject_count <= r_reject_count + 16'd1;
        end
    end

    assign reject_count = r_reject_count;
`endif

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_code   = r_rsp_code;
    assign rsp_flat   = r_rsp_flat;
    assign gate_open  = r_gate_open;
    assign exit_err   = r_exit_err;
    assign occ_bitmap = r_bitmap;
    assign occ_count  = r_count;

endmodule

// File: tb/tb_reserved_slot_entry_ctrl.sv
// Directed bench for reserved_slot_entry_ctrl (N_SLOTS=32, GATE_CYCLES=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reserved_slot_entry_ctrl;

    localparam int N_SLOTS     = 32;
    localparam int FLAT_W      = 6;
    localparam int GATE_CYCLES = 8;
    localparam logic [1:0] GRANTED  = 2'b00;
    localparam logic [1:0] OCCUPIED = 2'b01;
    localparam logic [1:0] INVALID  = 2'b10;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [FLAT_W-1:0]  req_flat;
    logic               exit_valid;
    logic [FLAT_W-1:0]  exit_flat;
    logic               rsp_valid;
    logic [1:0]         rsp_code;
    logic [FLAT_W-1:0]  rsp_flat;
    logic               gate_open;
    logic               exit_err;
    logic [N_SLOTS-1:0] occ_bitmap;
    logic [FLAT_W-1:0]  occ_count;
`ifdef ENTRY_STATS_EN
    logic [15:0]        reject_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reserved_slot_entry_ctrl #(
        .N_SLOTS    (N_SLOTS),
        .FLAT_W     (FLAT_W),
        .GATE_CYCLES(GATE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_flat    (req_flat),
        .exit_valid  (exit_valid),
        .exit_flat   (exit_flat),
        .rsp_valid   (rsp_valid),
        .rsp_code    (rsp_code),
        .rsp_flat    (rsp_flat),
        .gate_open   (gate_open),
        .exit_err    (exit_err),
        .occ_bitmap  (occ_bitmap),
`ifdef ENTRY_STATS_EN
        .reject_count(reject_count),
`endif
        .occ_count   (occ_count)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Issues one request; optionally pulses exit at step ex_step (step 0 = CHECK cycle).
    task automatic do_req(input int flat, input logic [1:0] exp_code,
                          input int ex_step, input int ex_flat, input logic exp_err);
        int last;
        @(negedge clk);
        check_val("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_flat  = flat[FLAT_W-1:0];
        last = (exp_code == GRANTED) ? GATE_CYCLES + 1 : 1;
        for (int s = 0; s <= last; s++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            exit_valid = (s == ex_step);
            exit_flat  = ex_flat[FLAT_W-1:0];
            check_val("exit_err", exit_err, (s == ex_step + 1) ? exp_err : 1'b0);
            if (s == 0) begin
                check_val("check_quiet", {gate_open, rsp_valid}, 0);
            end else if (s < last) begin
                check_val("gate_open", gate_open, 1);
                check_val("gate_no_rsp", rsp_valid, 0);
            end else begin
                check_val("rsp_valid", rsp_valid, 1);
                check_val("rsp_code", rsp_code, exp_code);
                check_val("rsp_flat", rsp_flat, flat);
                check_val("gate_closed", gate_open, 0);
            end
        end
        @(negedge clk);
        exit_valid = 1'b0;
        check_val("rsp_one_cycle", rsp_valid, 0);
        check_val("rsp_code_hold", rsp_code, exp_code);
        check_val("ready_after", req_ready, 1);
        $display("req flat=%0d code=%0d count=%0d bitmap=%08h", flat, rsp_code, occ_count, occ_bitmap);
    endtask

    task automatic pulse_exit(input int flat, input logic exp_err);
        @(negedge clk);
        exit_valid = 1'b1;
        exit_flat  = flat[FLAT_W-1:0];
        @(negedge clk);
        exit_valid = 1'b0;
        check_val("exit_err_pulse", exit_err, exp_err);
        @(negedge clk);
        check_val("exit_err_clear", exit_err, 0);
        $display("exit flat=%0d err=%0d count=%0d bitmap=%08h", flat, exp_err, occ_count, occ_bitmap);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_flat = '0; exit_valid = 1'b0; exit_flat = '0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", req_ready, 1);
        check_val("rst_bitmap", occ_bitmap, 0);
        check_val("rst_count", occ_count, 0);
        check_val("rst_rsp", {rsp_valid, rsp_code, rsp_flat}, 0);
        check_val("rst_gate_err", {gate_open, exit_err}, 0);
        rst = 1'b0;

        do_req(5, GRANTED, -1, 0, 1'b0);
        check_val("grant5_bitmap", occ_bitmap, 32'h0000_0010);
        check_val("grant5_count", occ_count, 1);

        do_req(5, OCCUPIED, -1, 0, 1'b0);
        check_val("occ5_bitmap", occ_bitmap, 32'h0000_0010);
        do_req(0, INVALID, -1, 0, 1'b0);
        do_req(33, INVALID, -1, 0, 1'b0);
        check_val("inv_bitmap", occ_bitmap, 32'h0000_0010);
        check_val("inv_count", occ_count, 1);
`ifdef ENTRY_STATS_EN
        check_val("reject_count", reject_count, 3);
`endif

        // Exit of flat 5 in the middle of flat 9's gate window.
        do_req(9, GRANTED, 3, 5, 1'b0);
        check_val("exit_in_gate_bitmap", occ_bitmap, 32'h0000_0100);
        check_val("exit_in_gate_count", occ_count, 1);
        pulse_exit(5, 1'b1);
        check_val("bad_exit_bitmap", occ_bitmap, 32'h0000_0100);

        // Grant of flat 3 and exit of flat 9 on the same edge.
        do_req(3, GRANTED, 0, 9, 1'b0);
        check_val("swap_bitmap", occ_bitmap, 32'h0000_0004);
        check_val("swap_count", occ_count, 1);

        for (int f = 1; f <= N_SLOTS; f++) begin
            if (f != 3) do_req(f, GRANTED, -1, 0, 1'b0);
        end
        check_val("full_bitmap", occ_bitmap, 32'hFFFF_FFFF);
        check_val("full_count", occ_count, 32);

        do_req(7, OCCUPIED, 0, 7, 1'b0);
        check_val("full_exit7_bitmap", occ_bitmap, 32'hFFFF_FFBF);
        check_val("full_exit7_count", occ_count, 31);

        // Reset in the middle of a gate window.
        @(negedge clk);
        req_valid = 1'b1;
        req_flat  = 6'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_gate", gate_open, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_gate", gate_open, 0);
        check_val("rst_mid_bitmap", occ_bitmap, 0);
        check_val("rst_mid_count", occ_count, 0);
        check_val("rst_mid_rsp", rsp_valid, 0);
        check_val("rst_mid_ready", req_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < GATE_CYCLES + 2; i++) begin
            @(negedge clk);
            check_val("no_rsp_after_rst", {rsp_valid, gate_open}, 0);
        end
        do_req(1, GRANTED, -1, 0, 1'b0);
        check_val("post_rst_bitmap", occ_bitmap, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reserved_slot_entry_ctrl.md
Name: reserved_slot_entry_ctrl

Overview:
- Entry-side controller for the reserved parking section, one stage upstream of the exit stage.
- Accepts a flat number at the entry gate and validates it (1..N_SLOTS).
- Checks that flat's reserved slot in an occupancy bitmap, marks it occupied, opens the gate for a timed window and returns a status code.
- The exit stage clears occupancy through the exit port; the bitmap is the shared slot database.

Parameters:
- N_SLOTS, 32, number of reserved slots; flat k owns slot index k-1.
- FLAT_W, $clog2(N_SLOTS+1), width of flat-number fields.
- GATE_CYCLES, 8, clock cycles gate_open stays high after a grant; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  entry request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_flat  input  FLAT_W  flat number of the entering vehicle.
- exit_valid  input  1  single-cycle pulse from the exit stage.
- exit_flat  input  FLAT_W  flat whose slot is vacated.
- rsp_valid  output  1  single-cycle response strobe.
- rsp_code  output  2  00 GRANTED, 01 OCCUPIED, 10 INVALID, 11 unused.
- rsp_flat  output  FLAT_W  flat number the response refers to.
- gate_open  output  1  entry barrier open.
- exit_err  output  1  single-cycle pulse: exit for an invalid flat or an empty slot.
- occ_bitmap  output  N_SLOTS  registered occupancy, bit i = slot of flat i+1.
- occ_count  output  FLAT_W  number of occupied slots.

Behaviour:
- Reset (synchronous, active-high, clk domain only): state IDLE, occ_bitmap=0, occ_count=0, rsp_valid=0, rsp_code=00, rsp_flat=0, gate_open=0, exit_err=0, gate timer=0.
- Reset mid-operation aborts any request and gate window. No response is issued for the aborted request.
- FSM states: IDLE, CHECK, GATE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_flat into flat_q and go to CHECK.
- CHECK:
  - flat_q==0 or flat_q>N_SLOTS: code=INVALID, go to RESP.
  - occ_bitmap[flat_q-1]==1 (registered value): code=OCCUPIED, go to RESP.
  - Otherwise: set the bit, occ_count+1, code=GRANTED, load timer=GATE_CYCLES, go to GATE.
- GATE:
  - gate_open=1 and the timer decrements each cycle.
  - When the timer reaches 1, go to RESP. gate_open is high for exactly GATE_CYCLES cycles.
- RESP:
  - rsp_valid=1 for one cycle with rsp_code and rsp_flat=flat_q, then return to IDLE.
  - rsp_code and rsp_flat hold their values until the next response.
- Latency, with acceptance at edge T:
  - Reject: rsp_valid high in cycle T+2.
  - Grant: gate_open high in cycles T+2..T+1+GATE_CYCLES, rsp_valid high in cycle T+2+GATE_CYCLES.
- Exit port:
  - Processed in every state, including while busy and in the same cycle as a request.
  - Valid flat with its bit set: clear the bit next edge, occ_count-1.
  - Otherwise: bitmap unchanged, exit_err=1 for one cycle.
- Simultaneous grant and valid exit on different slots in one cycle: both bits update and occ_count is unchanged.
- Same slot in one cycle cannot conflict. A grant needs the bit clear, and an exit of a clear bit is an error with no bitmap change.
- Exit clearing the very bit CHECK reads that cycle: CHECK uses the pre-edge bitmap, so the result is OCCUPIED; the bit ends cleared.
- Full section (occ_count==N_SLOTS) needs no special path. Every valid flat returns OCCUPIED.
- occ_count never wraps: the bitmap guarantees 0..N_SLOTS.

Optional Feature:
- Macro: ENTRY_STATS_EN.
- Defined:
  - Adds output reject_count (16 bits), reset to 0.
  - Increments in the RESP cycle for every OCCUPIED or INVALID response.
  - Saturates at 16'hFFFF.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then request flat 5 (N_SLOTS=32, GATE_CYCLES=8) -> gate_open high 8 cycles; rsp_valid with code 00 and rsp_flat 5 at T+10; occ_bitmap[4]=1; occ_count=1.
- Repeat request flat 5 -> code 01 at T+2, gate_open stays 0, bitmap unchanged.
- Requests for flat 0 and flat 33 -> code 10 each at T+2, no state change; with ENTRY_STATS_EN, reject_count=2 (3 after the preceding OCCUPIED case).
- exit_flat=5 pulse during an unrelated GATE window -> bit 4 cleared and occ_count decremented with no disturbance to the grant; second exit_flat=5 -> exit_err pulse.
- Fill all 32 slots, then request flat 7 -> OCCUPIED; same cycle exit_flat=7 while in CHECK -> response 01, bit 6 ends cleared, occ_count=31.
- Assert rst during GATE -> next cycle gate_open=0, bitmap=0, no rsp_valid, req_ready=1.
